if_fetch_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the L1 instruction cache. It owns the program counter and issues one word-aligned fetch per cycle to the cache's core-side port (tag/index/offset/read, stall, 32-bit data). It absorbs miss stalls and redirects from the back end, and delivers `{pc, instr}` pairs to decode through a 2-entry buffer with a valid/ready handshake.

---
 rtl/if_fetch_stage.sv | 154 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage in front of the L1 I-cache.
// Owns the PC and issues one word-aligned read per cycle. Cache stalls
// and back-end redirects are absorbed here, and {pc, instr} pairs go to
// decode through a 2-entry buffer.
//
// Handshakes:
//  - Cache request: held stable until accepted (read_C_L1 && !stall);
//    a raised request never drops before acceptance.
//  - Decode: a beat transfers when instr_valid && instr_ready.
//    instr / instr_pc hold while instr_valid && !instr_ready.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [20:0] tag_C_L1,
    output logic [4:0]  index_C_L1,
    output logic [5:0]  offset,
    output logic        read_C_L1,
    output logic        flush,
    input  logic        stall,
    input  logic [31:0] read_data_L1_C,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        dbg_state_o
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_KILL  = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic        hold_q, hold_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_instr_q [2];

    logic [31:0] target;
    logic        stalled_req;
    logic        accept;
    logic        push;
    logic        pop;
    logic        wr_ptr;

    assign target      = redirect_pc & ~32'd3;

    // The address always reflects the current PC; it only changes once a
    // request is accepted, so it is naturally stable across a stall.
    assign tag_C_L1    = pc_q[31:11];
    assign index_C_L1  = pc_q[10:6];
    assign offset      = {pc_q[5:2], 2'b00};

    // In KILL the stalled refill must finish, so the request stays up.
    assign read_C_L1   = !rst && ((state_q == ST_KILL) || (count_q < 2'd2) || hold_q);
    assign stalled_req = read_C_L1 && stall;
    assign accept      = read_C_L1 && !stall;
    // Flush only aborts a lookup the cache has not committed to a refill.
    assign flush       = !rst && (state_q == ST_FETCH) && redirect_valid && !stalled_req;

    assign instr_valid = !rst && (count_q != 2'd0);
    assign pop         = instr_valid && instr_ready;
    // Responses in KILL and in a redirect cycle are discarded.
    assign push        = (state_q == ST_FETCH) && accept && !redirect_valid;
    assign wr_ptr      = rd_ptr_q ^ count_q[0];

    assign instr       = fifo_instr_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];
    assign dbg_state_o = state_q;

    // Next-state logic: redirect beats push, push/pop update occupancy.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        saved_pc_d = saved_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        hold_d     = stalled_req;

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    count_d = 2'd0;
                    if (stalled_req) begin
                        saved_pc_d = target;
                        state_d    = ST_KILL;
                    end else begin
                        pc_d = target;
                    end
                end else if (accept) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_KILL: begin
                count_d = 2'd0;
                if (redirect_valid) begin
                    saved_pc_d = target;
                end
                if (!stall) begin
                    pc_d    = redirect_valid ? target : saved_pc_q;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC_ALIGNED;
            saved_pc_q <= RESET_PC_ALIGNED;
            hold_q     <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            saved_pc_q <= saved_pc_d;
            hold_q     <= hold_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Buffer storage; occupancy is tracked by count_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr]    <= pc_q;
            fifo_instr_q[wr_ptr] <= read_data_L1_C;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by a random phase,
// all checked cycle by cycle against a transaction-level fetch model.
module tb_if_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [20:0] tag_C_L1;
    logic [4:0]  index_C_L1;
    logic [5:0]  offset;
    logic        read_C_L1;
    logic        flush;
    logic        stall;
    logic [31:0] read_data_L1_C;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        dbg_state_o;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(TB_RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .tag_C_L1       (tag_C_L1),
        .index_C_L1     (index_C_L1),
        .offset         (offset),
        .read_C_L1      (read_C_L1),
        .flush          (flush),
        .stall          (stall),
        .read_data_L1_C (read_data_L1_C),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .dbg_state_o    (dbg_state_o)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign read_data_L1_C = word_of({tag_C_L1, index_C_L1, offset});

    // ---------------- scoreboard / model ----------------
    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];      // expected {pc, instr} held for decode
    logic [31:0] m_pc;          // next address the stage should present
    logic [31:0] m_target;      // pending redirect target during a kill
    logic        m_kill;        // stalled response must be thrown away
    logic        m_prev_stalled;
    int          n_acc;
    int          n_watch;
    logic [31:0] watch_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs on the falling edge, advance the model,
    // then return just after the next rising edge for new stimulus.
    task automatic cycle();
        logic        exp_read;
        logic        exp_flush;
        logic        acc;
        logic        pop;
        logic [31:0] tgt;
        @(negedge clk);
        if (rst) begin
            chk("rst_outputs", {61'b0, read_C_L1, instr_valid, flush}, 64'd0);
            m_pc           = TB_RESET_PC;
            m_target       = TB_RESET_PC;
            m_kill         = 1'b0;
            m_prev_stalled = 1'b0;
            exp_q.delete();
        end else begin
            exp_read  = m_kill || m_prev_stalled || (exp_q.size() < 2);
            exp_flush = redirect_valid && !m_kill && !(exp_read && stall);
            chk("addr", {32'b0, tag_C_L1, index_C_L1, offset}, {32'b0, m_pc});
            chk("read", {63'b0, read_C_L1}, {63'b0, exp_read});
            chk("flush", {63'b0, flush}, {63'b0, exp_flush});
            chk("kill_state", {63'b0, dbg_state_o}, {63'b0, m_kill});
            chk("valid", {63'b0, instr_valid}, {63'b0, (exp_q.size() != 0)});
            if (exp_q.size() != 0) begin
                chk("head", {instr_pc, instr}, exp_q[0]);
            end
            if (read_C_L1 && !stall) n_acc++;
            if (instr_valid && instr_ready && instr_pc == watch_pc) n_watch++;

            acc = exp_read && !stall;
            pop = (exp_q.size() != 0) && instr_ready;
            tgt = redirect_pc & ~32'd3;
            if (pop) void'(exp_q.pop_front());
            if (m_kill) begin
                if (redirect_valid) m_target = tgt;
                if (!stall) begin
                    m_kill = 1'b0;
                    m_pc   = m_target;
                end
            end else if (redirect_valid) begin
                exp_q.delete();
                if (exp_read && stall) begin
                    m_kill   = 1'b1;
                    m_target = tgt;
                end else begin
                    m_pc = tgt;
                end
            end else if (acc) begin
                exp_q.push_back({m_pc, word_of(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            m_prev_stalled = exp_read && stall;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall          = 1'b0;
        instr_ready    = 1'b1;
        watch_pc       = 32'hFFFF_FFFF;
        n_acc          = 0;
        n_watch        = 0;
        m_pc           = TB_RESET_PC;
        m_target       = TB_RESET_PC;
        m_kill         = 1'b0;
        m_prev_stalled = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cycle();

        // Reset and hit stream
        rst = 1'b0;
        settle();
        chk("first_tag", {43'b0, tag_C_L1}, 64'h2);
        chk("first_index_offset", {53'b0, index_C_L1, offset}, 64'h0);
        chk("first_read", {63'b0, read_C_L1}, 64'd1);
        cycle();
        settle();
        chk("first_delivery_pc", {32'b0, instr_pc}, {32'b0, TB_RESET_PC});
        repeat (10) cycle();

        // Backpressure from an empty buffer
        instr_ready = 1'b0;
        redirect_to(32'h0000_0100);
        cycle();
        redirect_valid = 1'b0;
        n_acc = 0;
        repeat (5) cycle();
        chk("bp_accepts", 64'(n_acc), 64'd2);
        settle();
        chk("bp_read_low", {63'b0, read_C_L1}, 64'd0);
        instr_ready = 1'b1;
        repeat (6) cycle();

        // Miss stall at 0x40
        redirect_to(32'h0000_0040);
        cycle();
        redirect_valid = 1'b0;
        stall    = 1'b1;
        watch_pc = 32'h0000_0040;
        n_watch  = 0;
        repeat (8) cycle();
        stall = 1'b0;
        repeat (6) cycle();
        chk("miss_delivered_once", 64'(n_watch), 64'd1);

        // Redirect with two entries buffered
        instr_ready = 1'b0;
        repeat (3) cycle();
        redirect_to(32'h0000_2002);
        settle();
        chk("rh_flush_pulse", {63'b0, flush}, 64'd1);
        cycle();
        redirect_valid = 1'b0;
        settle();
        chk("rh_flush_drop", {63'b0, flush}, 64'd0);
        chk("rh_empty", {63'b0, instr_valid}, 64'd0);
        chk("rh_target", {32'b0, tag_C_L1, index_C_L1, offset}, 64'h2000);
        instr_ready = 1'b1;
        repeat (6) cycle();

        // Redirect twice during a miss
        stall = 1'b1;
        cycle();
        redirect_to(32'h0000_0300);
        settle();
        chk("rm_no_flush_a", {63'b0, flush}, 64'd0);
        cycle();
        redirect_to(32'h0000_0400);
        settle();
        chk("rm_no_flush_b", {63'b0, flush}, 64'd0);
        cycle();
        redirect_valid = 1'b0;
        cycle();
        stall = 1'b0;
        cycle();
        settle();
        chk("rm_target", {32'b0, tag_C_L1, index_C_L1, offset}, 64'h400);
        chk("rm_dropped", {63'b0, instr_valid}, 64'd0);
        repeat (6) cycle();

        // PC wrap
        redirect_to(32'hFFFF_FFF8);
        cycle();
        redirect_valid = 1'b0;
        cycle();
        cycle();
        settle();
        chk("wrap_to_zero", {32'b0, tag_C_L1, index_C_L1, offset}, 64'h0);
        repeat (4) cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            stall          = ($urandom_range(0, 99) < 30);
            instr_ready    = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            cycle();
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;
        instr_ready    = 1'b1;
        repeat (4) cycle();

        // Reset during a miss
        stall = 1'b1;
        repeat (3) cycle();
        rst = 1'b1;
        settle();
        chk("rst_mid_read", {63'b0, read_C_L1}, 64'd0);
        chk("rst_mid_valid", {63'b0, instr_valid}, 64'd0);
        repeat (2) cycle();
        rst   = 1'b0;
        stall = 1'b0;
        settle();
        chk("restart_addr", {32'b0, tag_C_L1, index_C_L1, offset}, {32'b0, TB_RESET_PC});
        chk("restart_read", {63'b0, read_C_L1}, 64'd1);
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
